// File: rtl/dnc_iter_engine_if.sv
// Handshake bundle for dnc_iter_engine: ciphertext in, plaintext out, plus busy flag.
// The engine connects through the slave modport, the producer/consumer side through master.
interface dnc_iter_engine_if #(
    parameter int WIDTH = 19
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_data;
    logic [WIDTH-1:0] key;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] output_data;
    logic             busy;

    modport master (
        output in_valid, input_data, key, out_ready,
        input  in_ready, out_valid, output_data, busy
    );

    modport slave (
        input  in_valid, input_data, key, out_ready,
        output in_ready, out_valid, output_data, busy
    );
endinterface

// File: rtl/dnc_iter_engine.sv
// Iterative decryptor: undoes ROUNDS add-rotate-xor rounds, one per clock,
// walking the round keys from ROUNDS-1 down to 0.
module dnc_iter_engine #(
    parameter int WIDTH  = 19,
    parameter int ROUNDS = 5,
    parameter int ROT    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    dnc_iter_engine_if.slave bus
);
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [RW-1:0]    rnd_q, rnd_d;

    logic [WIDTH-1:0] roundKey;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] decOut;

    // Inverse round: subtract the round key, rotate right by ROT, then xor the key back out
    always_comb begin
        roundKey = (key_q << rnd_q) | (key_q >> (WIDTH - 32'(rnd_q)));
        diff     = work_q - roundKey;
        decOut   = {diff[ROT-1:0], diff[WIDTH-1:ROT]} ^ roundKey;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        work_d          = work_q;
        key_d           = key_q;
        rnd_d           = rnd_q;
        bus.in_ready    = 1'b0;
        bus.out_valid   = 1'b0;
        bus.busy        = 1'b1;
        bus.output_data = work_q;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    work_d  = bus.input_data;
                    key_d   = bus.key;
                    rnd_d   = RW'(ROUNDS - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = decOut;
                if (rnd_q == '0) begin
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q - RW'(1);
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dnc_iter_engine.sv
// Self-checking bench for dnc_iter_engine: directed known-answer vectors,
// backpressure, mid-run reset, latched-key behaviour and a random round-trip.
module tb_dnc_iter_engine;
    localparam int W = 19;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dnc_iter_engine_if #(.WIDTH(W)) bus ();

    dnc_iter_engine #(.WIDTH(W), .ROUNDS(5), .ROT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] modelRotl(input logic [W-1:0] x, input int a);
        logic [W-1:0] r;
        r = x;
        for (int j = 0; j < a; j++) r = {r[W-2:0], r[W-1]};
        return r;
    endfunction

    // Forward cipher, written independently of the engine, to build ciphertexts
    function automatic logic [W-1:0] modelEncrypt(input logic [W-1:0] p, input logic [W-1:0] k);
        logic [W-1:0] x;
        logic [W-1:0] ki;
        x = p;
        for (int i = 0; i < 5; i++) begin
            ki = modelRotl(k, i);
            x  = modelRotl(x ^ ki, 3) + ki;
        end
        return x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] d, input logic [W-1:0] k);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        bus.input_data = d;
        bus.key        = k;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
    endtask

    task automatic waitResult(output int lat, output logic [W-1:0] data, input bit scramble);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (scramble) begin
                bus.in_valid   = 1'($urandom_range(0, 1));
                bus.key        = W'($urandom);
                bus.input_data = W'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        if (!bus.out_valid) checkOutput("result_timeout", 32'd0, 32'd1);
        data = bus.output_data;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic runDirected(input string tag, input logic [W-1:0] d, input logic [W-1:0] k,
                               input logic [W-1:0] exp);
        int           lat;
        logic [W-1:0] data;
        applyStimulus(d, k);
        waitResult(lat, data, 1'b0);
        checkOutput({tag, "_lat"}, lat, 32'd5);
        checkOutput({tag, "_data"}, data, exp);
        consume();
    endtask

    initial begin
        int           lat;
        logic [W-1:0] data;
        logic [W-1:0] held;
        logic [W-1:0] p;
        logic [W-1:0] k;
        bit           early;

        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.input_data = '0;
        bus.key        = '0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 32'd1);
        checkOutput("rst_out_valid", bus.out_valid, 32'd0);
        checkOutput("rst_busy", bus.busy, 32'd0);
        checkOutput("rst_data", bus.output_data, 32'd0);

        // Zero-key vectors, then check IDLE after consumption keeps the last result
        applyStimulus(19'd131078, 19'd0);
        checkOutput("run_busy", bus.busy, 32'd1);
        checkOutput("run_in_ready", bus.in_ready, 32'd0);
        waitResult(lat, data, 1'b0);
        checkOutput("zk100_lat", lat, 32'd5);
        checkOutput("zk100_data", data, 32'd100);
        checkOutput("done_busy", bus.busy, 32'd1);
        consume();
        checkOutput("idle_in_ready", bus.in_ready, 32'd1);
        checkOutput("idle_out_valid", bus.out_valid, 32'd0);
        checkOutput("idle_hold", bus.output_data, 32'd100);

        runDirected("zk_zero", 19'd0, 19'd0, 19'd0);
        runDirected("zk_ones", 19'h7FFFF, 19'd0, 19'h7FFFF);
        runDirected("ok_zero", 19'd0, 19'h7FFFF, 19'h71C6F);

        // Backpressure: 7-cycle stall with an ignored second in_valid pulse
        applyStimulus(19'd131078, 19'd0);
        waitResult(lat, held, 1'b0);
        checkOutput("bp_first", held, 32'd100);
        for (int c = 0; c < 7; c++) begin
            bus.in_valid   = (c == 3);
            bus.input_data = 19'h12345;
            @(negedge clk);
            bus.in_valid   = 1'b0;
            checkOutput("bp_valid", bus.out_valid, 32'd1);
            checkOutput("bp_in_ready", bus.in_ready, 32'd0);
            checkOutput("bp_stable", bus.output_data, held);
        end
        consume();
        checkOutput("bp_release_ready", bus.in_ready, 32'd1);
        checkOutput("bp_release_valid", bus.out_valid, 32'd0);
        checkOutput("bp_release_data", bus.output_data, 32'd100);

        // Reset taken at the third RUN edge aborts the word
        applyStimulus(19'd131078, 19'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mrst_in_ready", bus.in_ready, 32'd1);
        checkOutput("mrst_out_valid", bus.out_valid, 32'd0);
        checkOutput("mrst_busy", bus.busy, 32'd0);
        checkOutput("mrst_data", bus.output_data, 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("mrst_quiet", bus.out_valid, 32'd0);
        runDirected("mrst_next", 19'd131078, 19'd0, 19'd100);

        // Key and data wiggled during RUN must not disturb the latched operands
        applyStimulus(19'd0, 19'h7FFFF);
        bus.key        = 19'd0;
        bus.input_data = 19'h55555;
        waitResult(lat, data, 1'b0);
        checkOutput("latched_key", data, 32'h71C6F);
        consume();

        for (int n = 0; n < 1000; n++) begin
            p     = W'($urandom);
            k     = W'($urandom);
            early = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(modelEncrypt(p, k), k);
            if (early) bus.out_ready = 1'b1;
            waitResult(lat, data, 1'b1);
            checkOutput("rt_lat", lat, 32'd5);
            checkOutput("rt_data", data, p);
            if (!early) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            bus.out_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
